// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with return-address stack and relative branching
//
// Purpose: fetch-path PC register. It supports absolute load, signed relative branch,
// call (push return address), return (pop) and call+return swap. Each of these can be
// followed by an optional post-increment. The unit has sticky stack error flags.
//
// Optional feature macro: PC_STACK_UNIT_PREV_EN (adds prev_value / discontinuity).
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   a, b                     tri-state buses; carry value when oe_a / oe_b, else high-Z
//   in                       absolute target (ld/call) or two's-complement offset (ld_rel)
//   oe_a, oe_b               bus output enables
//   ld, ld_rel, call, ret    PC commands, priority call&ret > ret > call > ld > ld_rel
//   post_inc                 add INC_STEP after the selected command
//   clr_err                  clear sticky error flags (a new error in the same cycle wins)
//   value                    current PC
//   ras_empty, ras_full      stack occupancy status
//   ras_overflow             sticky: push while full
//   ras_underflow            sticky: pop while empty
//   prev_value, discontinuity  (PC_STACK_UNIT_PREV_EN) PC before the last taken jump

module pc_stack_unit #(
    parameter int              SIZE        = 32,
    parameter logic [SIZE-1:0] INITIAL_VAL = '0,
    parameter int              RAS_DEPTH   = 8,
    parameter int              INC_STEP    = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [SIZE-1:0] a,
    output logic [SIZE-1:0] b,
    input  logic [SIZE-1:0] in,
    input  logic            oe_a,
    input  logic            oe_b,
    input  logic            ld,
    input  logic            ld_rel,
    input  logic            call,
    input  logic            ret,
    input  logic            post_inc,
    input  logic            clr_err,
    output logic [SIZE-1:0] value,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
`ifdef PC_STACK_UNIT_PREV_EN
    output logic [SIZE-1:0] prev_value,
    output logic            discontinuity,
`endif
    output logic            ras_underflow
);

    localparam int              PW     = $clog2(RAS_DEPTH);
    localparam logic [SIZE-1:0] L_INC  = SIZE'(INC_STEP);
    localparam logic [PW:0]     L_FULL = (PW+1)'(RAS_DEPTH);

    logic [SIZE-1:0] r_value;
    logic [SIZE-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]   r_top;
    logic [PW:0]     r_count;
    logic            r_ovf;
    logic            r_unf;

    logic [SIZE-1:0] w_ret_addr;
    logic [SIZE-1:0] w_target;
    logic [SIZE-1:0] w_next;
    logic            w_push;
    logic            w_pop;
    logic            w_swap;
    logic            w_ovf_set;
    logic            w_unf_set;
    logic            w_taken;

    assign ras_empty  = (r_count == '0);
    assign ras_full   = (r_count == L_FULL);
    assign w_ret_addr = r_value + L_INC;

    always_comb begin
        w_target  = r_value;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_swap    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_taken   = 1'b0;
        if (call && ret) begin
            w_taken = 1'b1;
            // An empty swap has nothing to return to, so the call half is dropped as well.
            if (ras_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_target = r_stack[r_top];
                w_swap   = 1'b1;
            end
        end else if (ret) begin
            w_taken = 1'b1;
            if (ras_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_target = r_stack[r_top];
                w_pop    = 1'b1;
            end
        end else if (call) begin
            w_taken   = 1'b1;
            w_target  = in;
            w_push    = 1'b1;
            w_ovf_set = ras_full;
        end else if (ld) begin
            w_taken  = 1'b1;
            w_target = in;
        end else if (ld_rel) begin
            // Modular addition treats in as two's complement without sign extension logic.
            w_taken  = 1'b1;
            w_target = r_value + in;
        end
    end

    assign w_next = w_target + (post_inc ? L_INC : '0);

    // Storage is not reset. Pointer and count reset make any contents unreachable.
    // A push into a full buffer advances onto the oldest slot, which overwrites it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_push) begin
                r_stack[r_top + PW'(1)] <= w_ret_addr;
            end else if (w_swap) begin
                r_stack[r_top] <= w_ret_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= INITIAL_VAL;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_value <= w_next;
            if (w_push) begin
                r_top <= r_top + PW'(1);
                if (!ras_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_top   <= r_top - PW'(1);
                r_count <= r_count - 1'b1;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (clr_err) begin
                r_unf <= 1'b0;
            end
        end
    end

`ifdef PC_STACK_UNIT_PREV_EN
    logic [SIZE-1:0] r_prev;
    logic            r_disc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= INITIAL_VAL;
            r_disc <= 1'b0;
        end else begin
            r_disc <= w_taken;
            if (w_taken) begin
                r_prev <= r_value;
            end
        end
    end

    assign prev_value    = r_prev;
    assign discontinuity = r_disc;
`endif

    assign value         = r_value;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;
    assign a = oe_a ? r_value : {SIZE{1'bz}};
    assign b = oe_b ? r_value : {SIZE{1'bz}};

endmodule
